// File: rtl/riscv_mem_arbiter_if.sv
// Signal bundle for riscv_mem_arbiter: fetch port, load/store port and the shared memory port.
// The master modport is the arbiter's view; the slave modport is the core plus memory side.
interface riscv_mem_arbiter_if;
   // Instruction-fetch port (read-only)
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        i_err;

   // Load/store port
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;

   // Unified memory port
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      input  i_req, i_addr,
      output i_gnt, i_rvalid, i_rdata, i_err,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      output i_req, i_addr,
      input  i_gnt, i_rvalid, i_rdata, i_err,
      output d_req, d_we, d_be, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between RV32I fetch (I) and load/store (D), one transaction in flight,
// with a response watchdog that turns a silent memory into an error response.
module riscv_mem_arbiter #(
   parameter int DATA_PRIORITY  = 0,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic                 clk,
   input logic                 rst_n,
   riscv_mem_arbiter_if.master bus
);

   localparam int TIMER_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam bit WATCHDOG_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT
   } state_e;

   typedef enum logic {
      PORT_I,
      PORT_D
   } port_e;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_cmd_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   state_e             state_q, state_d;
   port_e              owner_q, owner_d;
   port_e              last_q, last_d;
   logic               mem_req_q, mem_req_d;
   mem_cmd_t           cmd_q, cmd_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   rsp_t               i_rsp_q, i_rsp_d;
   rsp_t               d_rsp_q, d_rsp_d;

   port_e              winner;
   rsp_t               rsp;

   // Arbitration: a lone requester wins; ties go to D or to whoever did not own the last slot.
   always_comb begin
      winner = PORT_D;
      if (bus.i_req && !bus.d_req) begin
         winner = PORT_I;
      end else if (bus.i_req && bus.d_req) begin
         if (DATA_PRIORITY != 0) winner = PORT_D;
         else                    winner = (last_q == PORT_I) ? PORT_D : PORT_I;
      end
   end

   // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      mem_req_d = mem_req_q;
      cmd_d     = cmd_q;
      timer_d   = timer_q;
      rsp       = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.i_req || bus.d_req) begin
               if (winner == PORT_I) begin
                  cmd_d = '{we: 1'b0, be: 4'b1111, addr: bus.i_addr, wdata: 32'h0};
               end else begin
                  cmd_d = '{we: bus.d_we, be: bus.d_be, addr: bus.d_addr, wdata: bus.d_wdata};
               end
               owner_d   = winner;
               last_d    = winner;
               mem_req_d = 1'b1;
               state_d   = ST_REQ;
            end
         end

         // The command stays frozen until memory accepts it; stalls here are unbounded.
         ST_REQ: begin
            if (bus.mem_gnt) begin
               mem_req_d = 1'b0;
               timer_d   = '0;
               state_d   = ST_WAIT;
            end
         end

         ST_WAIT: begin
            timer_d = timer_q + TIMER_W'(1);
            if (bus.mem_rvalid) begin
               rsp     = '{valid: 1'b1, rdata: bus.mem_rdata, err: 1'b0};
               state_d = ST_IDLE;
            end else if (WATCHDOG_EN && (timer_q == TIMER_LAST)) begin
               rsp     = '{valid: 1'b1, rdata: 32'h0, err: 1'b1};
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Only the owner sees the response; the other port stays all-zero.
      i_rsp_d = (owner_q == PORT_I) ? rsp : '0;
      d_rsp_d = (owner_q == PORT_D) ? rsp : '0;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         owner_q   <= PORT_D;
         last_q    <= PORT_D;
         mem_req_q <= 1'b0;
         cmd_q     <= '0;
         timer_q   <= '0;
         i_rsp_q   <= '0;
         d_rsp_q   <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         mem_req_q <= mem_req_d;
         cmd_q     <= cmd_d;
         timer_q   <= timer_d;
         i_rsp_q   <= i_rsp_d;
         d_rsp_q   <= d_rsp_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = cmd_q.we;
   assign bus.mem_be    = cmd_q.be;
   assign bus.mem_addr  = cmd_q.addr;
   assign bus.mem_wdata = cmd_q.wdata;

   // Grants pass straight through from memory; a reset cycle suppresses them for the abandoned request.
   assign bus.i_gnt = rst_n && (state_q == ST_REQ) && bus.mem_gnt && (owner_q == PORT_I);
   assign bus.d_gnt = rst_n && (state_q == ST_REQ) && bus.mem_gnt && (owner_q == PORT_D);

   assign bus.i_rvalid = i_rsp_q.valid;
   assign bus.i_rdata  = i_rsp_q.rdata;
   assign bus.i_err    = i_rsp_q.err;
   assign bus.d_rvalid = d_rsp_q.valid;
   assign bus.d_rdata  = d_rsp_q.rdata;
   assign bus.d_err    = d_rsp_q.err;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: dut0 is round-robin, dut1 is data-priority, both with
// a 16-cycle watchdog and fed identical stimulus.
module tb_riscv_mem_arbiter;

   localparam logic P_I = 1'b0;
   localparam logic P_D = 1'b1;

   typedef struct {
      logic        port;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          cyc;
   } gnt_exp_t;

   typedef struct {
      logic        port;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } rsp_exp_t;

   logic clk;
   logic rst_n;

   riscv_mem_arbiter_if bus0();
   riscv_mem_arbiter_if bus1();

   riscv_mem_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0)
   );
   riscv_mem_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );

   // dut1 mirrors dut0's inputs; arbitration policy does not change handshake timing.
   assign bus1.i_req      = bus0.i_req;
   assign bus1.i_addr     = bus0.i_addr;
   assign bus1.d_req      = bus0.d_req;
   assign bus1.d_we       = bus0.d_we;
   assign bus1.d_be       = bus0.d_be;
   assign bus1.d_addr     = bus0.d_addr;
   assign bus1.d_wdata    = bus0.d_wdata;
   assign bus1.mem_gnt    = bus0.mem_gnt;
   assign bus1.mem_rvalid = bus0.mem_rvalid;
   assign bus1.mem_rdata  = bus0.mem_rdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   gnt_exp_t    exp_gnt[$];
   rsp_exp_t    exp_rsp[$];
   logic        exp_gnt1[$];

   int          vectors;
   int          miscompares;
   int          cyc;
   bit          chk1;
   bit          auto_mem;
   logic        pend;
   logic        pend_we;
   logic [31:0] pend_addr;

   function automatic logic [31:0] mem_fn(input logic we, input logic [31:0] a);
      return we ? 32'h0 : (a ^ 32'hC0DE_0000);
   endfunction

   task automatic idle_inputs();
      bus0.i_req      = 1'b0;
      bus0.i_addr     = 32'h0;
      bus0.d_req      = 1'b0;
      bus0.d_we       = 1'b0;
      bus0.d_be       = 4'h0;
      bus0.d_addr     = 32'h0;
      bus0.d_wdata    = 32'h0;
      bus0.mem_gnt    = 1'b0;
      bus0.mem_rvalid = 1'b0;
      bus0.mem_rdata  = 32'h0;
   endtask

   task automatic push_txn(input logic p, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic err,
                           input int gcyc, input int rcyc);
      exp_gnt.push_back('{port: p, we: we, be: be, addr: addr, wdata: wdata, cyc: gcyc});
      if (rcyc >= 0) exp_rsp.push_back('{port: p, rdata: rdata, err: err, cyc: rcyc});
   endtask

   // Scoreboard: pop the expectation whenever dut0 grants or responds.
   task automatic monitor();
      gnt_exp_t g;
      rsp_exp_t r;
      logic     p;
      if (bus0.i_gnt || bus0.d_gnt) begin
         vectors++;
         if (exp_gnt.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_gnt cycle %0d: i_gnt=%b d_gnt=%b, required no grant",
                     cyc, bus0.i_gnt, bus0.d_gnt);
         end else begin
            g = exp_gnt.pop_front();
            if ({bus0.i_gnt, bus0.d_gnt, bus0.mem_req, bus0.mem_we, bus0.mem_be, bus0.mem_addr, bus0.mem_wdata}
                !== {g.port == P_I, g.port == P_D, 1'b1, g.we, g.be, g.addr, g.wdata} || cyc != g.cyc) begin
               miscompares++;
               $display("FAIL gnt cycle %0d: i_gnt=%b d_gnt=%b req=%b we=%b be=%h addr=%h wdata=%h; required port=%s we=%b be=%h addr=%h wdata=%h at cycle %0d",
                        cyc, bus0.i_gnt, bus0.d_gnt, bus0.mem_req, bus0.mem_we, bus0.mem_be, bus0.mem_addr,
                        bus0.mem_wdata, (g.port == P_I) ? "I" : "D", g.we, g.be, g.addr, g.wdata, g.cyc);
            end
         end
      end

      vectors++;
      if (bus0.i_rvalid || bus0.d_rvalid) begin
         if (exp_rsp.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_rsp cycle %0d: i_rvalid=%b d_rvalid=%b, required no response",
                     cyc, bus0.i_rvalid, bus0.d_rvalid);
         end else begin
            r = exp_rsp.pop_front();
            if ({bus0.i_rvalid, bus0.d_rvalid, bus0.i_rdata, bus0.d_rdata, bus0.i_err, bus0.d_err}
                !== {r.port == P_I, r.port == P_D,
                     (r.port == P_I) ? r.rdata : 32'h0, (r.port == P_D) ? r.rdata : 32'h0,
                     (r.port == P_I) && r.err, (r.port == P_D) && r.err} || cyc != r.cyc) begin
               miscompares++;
               $display("FAIL rsp cycle %0d: i_rvalid=%b i_rdata=%h i_err=%b d_rvalid=%b d_rdata=%h d_err=%b; required port=%s rdata=%h err=%b at cycle %0d",
                        cyc, bus0.i_rvalid, bus0.i_rdata, bus0.i_err, bus0.d_rvalid, bus0.d_rdata, bus0.d_err,
                        (r.port == P_I) ? "I" : "D", r.rdata, r.err, r.cyc);
            end
         end
      end else if ({bus0.i_rdata, bus0.d_rdata, bus0.i_err, bus0.d_err} !== 66'h0) begin
         miscompares++;
         $display("FAIL idle_rsp_fields cycle %0d: i_rdata=%h i_err=%b d_rdata=%h d_err=%b, required all 0",
                  cyc, bus0.i_rdata, bus0.i_err, bus0.d_rdata, bus0.d_err);
      end

      if (chk1 && (bus1.i_gnt || bus1.d_gnt)) begin
         vectors++;
         if (exp_gnt1.size() == 0) begin
            miscompares++;
            $display("FAIL prio_unexpected_gnt cycle %0d: i_gnt=%b d_gnt=%b", cyc, bus1.i_gnt, bus1.d_gnt);
         end else begin
            p = exp_gnt1.pop_front();
            if ({bus1.i_gnt, bus1.d_gnt} !== {p == P_I, p == P_D}) begin
               miscompares++;
               $display("FAIL prio_owner cycle %0d: i_gnt=%b d_gnt=%b, required owner %s",
                        cyc, bus1.i_gnt, bus1.d_gnt, (p == P_I) ? "I" : "D");
            end
         end
      end
   endtask

   // half(): drive the memory model, then sample on the falling edge; fin(): cross the rising edge.
   task automatic half();
      if (auto_mem) begin
         bus0.mem_gnt    = bus0.mem_req;
         bus0.mem_rvalid = pend;
         bus0.mem_rdata  = pend ? mem_fn(pend_we, pend_addr) : 32'h0;
      end
      @(negedge clk);
      monitor();
      if (auto_mem) begin
         pend      = bus0.mem_gnt && bus0.mem_req;
         pend_we   = bus0.mem_we;
         pend_addr = bus0.mem_addr;
      end
   endtask

   task automatic fin();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic tick();
      half();
      fin();
   endtask

   task automatic run_fetch(input logic [31:0] addr, input logic [31:0] rdata);
      int c0;
      c0 = cyc;
      push_txn(P_I, 1'b0, 4'hF, addr, 32'h0, rdata, 1'b0, c0 + 1, c0 + 3);
      bus0.i_req = 1'b1; bus0.i_addr = addr;
      tick();
      bus0.mem_gnt = 1'b1;
      tick();
      bus0.i_req = 1'b0; bus0.mem_gnt = 1'b0;
      bus0.mem_rvalid = 1'b1; bus0.mem_rdata = rdata;
      tick();
      bus0.mem_rvalid = 1'b0; bus0.mem_rdata = 32'h0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      half();
      vectors++;
      if ({bus0.mem_req, bus0.mem_we, bus0.mem_be, bus0.mem_addr, bus0.mem_wdata, bus0.i_gnt, bus0.d_gnt,
           bus0.i_rvalid, bus0.d_rvalid, bus0.i_rdata, bus0.d_rdata, bus0.i_err, bus0.d_err} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: mem_req=%b mem_addr=%h i_rvalid=%b d_rvalid=%b, required all 0",
                  bus0.mem_req, bus0.mem_addr, bus0.i_rvalid, bus0.d_rvalid);
      end
      fin();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_fetch();
      run_fetch(32'h0000_0100, 32'h0050_0093);
   endtask

   task automatic test_contention();
      int   c0;
      logic p;
      bus0.i_req = 1'b1; bus0.i_addr = 32'h1000;
      bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_be = 4'hF;
      bus0.d_addr = 32'h2000; bus0.d_wdata = 32'h1111_2222;
      auto_mem = 1'b1; pend = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      c0 = cyc;
      for (int k = 0; k < 4; k++) begin
         p = (k % 2 == 0) ? P_I : P_D;
         if (p == P_I) push_txn(P_I, 1'b0, 4'hF, 32'h1000, 32'h0, mem_fn(1'b0, 32'h1000), 1'b0,
                                c0 + 1 + 3 * k, c0 + 3 + 3 * k);
         else          push_txn(P_D, 1'b0, 4'hF, 32'h2000, 32'h1111_2222, mem_fn(1'b0, 32'h2000), 1'b0,
                                c0 + 1 + 3 * k, c0 + 3 + 3 * k);
         exp_gnt1.push_back(P_D);
      end
      chk1 = 1'b1;
      for (int t = 0; t < 14; t++) begin
         if (t == 11) begin
            bus0.i_req = 1'b0; bus0.d_req = 1'b0;
         end
         tick();
      end
      chk1 = 1'b0;
      auto_mem = 1'b0;
      idle_inputs();
      tick();
   endtask

   task automatic test_store_stall();
      int c0;
      c0 = cyc;
      push_txn(P_D, 1'b1, 4'b0011, 32'h204, 32'hDEAD_BEEF, 32'h0, 1'b0, c0 + 6, c0 + 8);
      bus0.d_req = 1'b1; bus0.d_we = 1'b1; bus0.d_be = 4'b0011;
      bus0.d_addr = 32'h204; bus0.d_wdata = 32'hDEAD_BEEF;
      tick();
      for (int s = 0; s < 5; s++) begin
         half();
         vectors++;
         if ({bus0.mem_req, bus0.mem_we, bus0.mem_be, bus0.mem_addr, bus0.mem_wdata, bus0.d_gnt, bus0.i_gnt}
             !== {1'b1, 1'b1, 4'b0011, 32'h204, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_hold stall %0d: req=%b we=%b be=%h addr=%h wdata=%h d_gnt=%b, required 1 1 3 00000204 deadbeef 0",
                     s, bus0.mem_req, bus0.mem_we, bus0.mem_be, bus0.mem_addr, bus0.mem_wdata, bus0.d_gnt);
         end
         fin();
      end
      bus0.mem_gnt = 1'b1;
      tick();
      idle_inputs();
      bus0.mem_rvalid = 1'b1;
      tick();
      bus0.mem_rvalid = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_timeout();
      int c0;
      c0 = cyc;
      push_txn(P_D, 1'b0, 4'hF, 32'h300, 32'h0, 32'h0, 1'b1, c0 + 1, c0 + 18);
      bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_be = 4'hF; bus0.d_addr = 32'h300; bus0.d_wdata = 32'h0;
      tick();
      bus0.mem_gnt = 1'b1;
      tick();
      idle_inputs();
      repeat (17) tick();
      // A late response after the watchdog fired must be swallowed.
      bus0.mem_rvalid = 1'b1; bus0.mem_rdata = 32'hBAD0_BAD0;
      tick();
      bus0.mem_rvalid = 1'b0; bus0.mem_rdata = 32'h0;
      tick();
      run_fetch(32'h0000_0400, 32'h0000_0013);
   endtask

   task automatic test_reset_mid_wait();
      int c1;
      push_txn(P_I, 1'b0, 4'hF, 32'h500, 32'h0, 32'h0, 1'b0, cyc + 1, -1);
      bus0.i_req = 1'b1; bus0.i_addr = 32'h500;
      tick();
      bus0.mem_gnt = 1'b1;
      tick();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus0.mem_rvalid = 1'b1; bus0.mem_rdata = 32'h77;
      half();
      vectors++;
      if ({bus0.mem_req, bus0.mem_we, bus0.mem_be, bus0.mem_addr, bus0.mem_wdata, bus0.i_gnt, bus0.d_gnt,
           bus0.i_rvalid, bus0.d_rvalid, bus0.i_rdata, bus0.d_rdata, bus0.i_err, bus0.d_err} !== '0) begin
         miscompares++;
         $display("FAIL post_reset_outputs: mem_req=%b mem_addr=%h i_rvalid=%b d_rvalid=%b, required all 0",
                  bus0.mem_req, bus0.mem_addr, bus0.i_rvalid, bus0.d_rvalid);
      end
      fin();
      bus0.mem_rvalid = 1'b0; bus0.mem_rdata = 32'h0;
      tick();
      tick();

      // Tie after reset goes to I, then the held D request follows.
      c1 = cyc;
      push_txn(P_I, 1'b0, 4'hF, 32'h600, 32'h0, mem_fn(1'b0, 32'h600), 1'b0, c1 + 1, c1 + 3);
      push_txn(P_D, 1'b0, 4'hF, 32'h604, 32'h0, mem_fn(1'b0, 32'h604), 1'b0, c1 + 4, c1 + 6);
      bus0.i_req = 1'b1; bus0.i_addr = 32'h600;
      bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_be = 4'hF; bus0.d_addr = 32'h604; bus0.d_wdata = 32'h0;
      auto_mem = 1'b1; pend = 1'b0;
      for (int t = 0; t < 8; t++) begin
         if (t == 2) bus0.i_req = 1'b0;
         if (t == 5) bus0.d_req = 1'b0;
         tick();
      end
      auto_mem = 1'b0;
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      int c0;
      c0 = cyc;
      for (int k = 0; k < 4; k++) begin
         push_txn(P_I, 1'b0, 4'hF, 32'h800 + 32'(4 * k), 32'h0, mem_fn(1'b0, 32'h800 + 32'(4 * k)), 1'b0,
                  c0 + 1 + 3 * k, c0 + 3 + 3 * k);
      end
      auto_mem = 1'b1; pend = 1'b0;
      bus0.i_req = 1'b1;
      for (int t = 0; t < 14; t++) begin
         bus0.i_addr = 32'h800 + 32'(4 * (t / 3));
         if (t == 11) bus0.i_req = 1'b0;
         half();
         // The response cycle is the next arbitration cycle; mem_req follows one cycle later.
         if (t == 3 || t == 6 || t == 9) begin
            vectors++;
            if (bus0.mem_req !== 1'b0) begin
               miscompares++;
               $display("FAIL b2b_arb_cycle t=%0d: mem_req=%b, required 0", t, bus0.mem_req);
            end
         end
         if (t == 4 || t == 7 || t == 10) begin
            vectors++;
            if ({bus0.mem_req, bus0.mem_addr} !== {1'b1, 32'h800 + 32'(4 * (t / 3))}) begin
               miscompares++;
               $display("FAIL b2b_next_req t=%0d: mem_req=%b mem_addr=%h, required 1 %h",
                        t, bus0.mem_req, bus0.mem_addr, 32'h800 + 32'(4 * (t / 3)));
            end
         end
         fin();
      end
      auto_mem = 1'b0;
      idle_inputs();
      tick();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      chk1        = 1'b0;
      auto_mem    = 1'b0;
      pend        = 1'b0;
      pend_we     = 1'b0;
      pend_addr   = 32'h0;
      rst_n       = 1'b0;
      idle_inputs();

      test_reset();
      test_single_fetch();
      test_contention();
      test_store_stall();
      test_timeout();
      test_reset_mid_wait();
      test_back_to_back();

      vectors++;
      if (exp_gnt.size() != 0 || exp_rsp.size() != 0 || exp_gnt1.size() != 0) begin
         miscompares++;
         $display("FAIL leftover_expectations: gnt=%0d rsp=%0d prio_gnt=%0d outstanding, required 0",
                  exp_gnt.size(), exp_rsp.size(), exp_gnt1.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
